// File: rtl/mem_line_master.sv
// Miss-service initiator for the 128-bit slow_memory block port: optional dirty
// write-back followed by optional refill, with per-transaction timeout.
module mem_line_master #(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wb,
  input  logic         req_fill,
  input  logic [27:0]  wb_addr,
  input  logic [127:0] wb_data,
  input  logic [27:0]  fill_addr,
  output logic         done,
  output logic         fill_valid,
  output logic [127:0] fill_data,
  output logic         err,
  output logic [15:0]  busy_cycles,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_REQ   = 3'd1,
    GAP      = 3'd2,
    FILL_REQ = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  state_t         state_r;
  state_t         state_s;
  logic [CW-1:0]  wait_r;
  logic [27:0]    fill_addr_r;
  logic           fill_pend_r;
  logic           fill_ok_r;
  logic           wait_exp_s;

  assign wait_exp_s = (wait_r == WAIT_LAST);

  // Outputs decoded straight from the state register.
  assign req_ready  = (state_r == IDLE);
  assign mem_write  = (state_r == WB_REQ);
  assign mem_read   = (state_r == FILL_REQ);
  assign done       = (state_r == RESP);
  assign fill_valid = (state_r == RESP) && fill_ok_r;

  // Next-state decode; a ready on the last allowed wait cycle still wins over the abort.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_wb) begin
          state_s = WB_REQ;
        end else if (req_valid && req_fill) begin
          state_s = FILL_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      WB_REQ: begin
        if (mem_ready) begin
          state_s = fill_pend_r ? GAP : RESP;
        end else if (wait_exp_s) begin
          state_s = RESP;
        end else begin
          state_s = WB_REQ;
        end
      end
      GAP: state_s = FILL_REQ;
      FILL_REQ: begin
        if (mem_ready || wait_exp_s) begin
          state_s = RESP;
        end else begin
          state_s = FILL_REQ;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, command latches, wait counter, memory-side registers and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wait_r      <= '0;
      fill_addr_r <= 28'd0;
      fill_pend_r <= 1'b0;
      fill_ok_r   <= 1'b0;
      mem_addr    <= 28'd0;
      mem_wdata   <= 128'd0;
      fill_data   <= 128'd0;
      err         <= 1'b0;
      busy_cycles <= 16'd0;
    end else begin
      state_r <= state_s;
      if ((state_r != IDLE) && (busy_cycles != 16'hFFFF)) begin
        busy_cycles <= busy_cycles + 16'd1;
      end
      case (state_r)
        IDLE: begin
          if (req_valid && (req_wb || req_fill)) begin
            fill_pend_r <= req_fill;
            fill_addr_r <= fill_addr;
            fill_ok_r   <= 1'b0;
            wait_r      <= '0;
            mem_addr    <= req_wb ? wb_addr : fill_addr;
            if (req_wb) begin
              mem_wdata <= wb_data;
            end
          end
        end
        WB_REQ: begin
          if (mem_ready) begin
            wait_r <= '0;
            if (fill_pend_r) begin
              mem_addr <= fill_addr_r;
            end
          end else if (wait_exp_s) begin
            err <= 1'b1;
          end else begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        FILL_REQ: begin
          if (mem_ready) begin
            fill_data <= mem_rdata;
            fill_ok_r <= 1'b1;
          end else if (wait_exp_s) begin
            err <= 1'b1;
          end else begin
            wait_r <= wait_r + WAIT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with an inline slow-memory responder
// driven cycle by cycle on the falling edge.
module tb_mem_line_master;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_wb, req_fill;
  logic [27:0]  wb_addr, fill_addr, mem_addr;
  logic [127:0] wb_data, fill_data, mem_wdata, mem_rdata;
  logic         done, fill_valid, err, mem_read, mem_write, mem_ready;
  logic [15:0]  busy_cycles;

  always #5 clk = ~clk;

  mem_line_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill), .wb_addr(wb_addr), .wb_data(wb_data),
    .fill_addr(fill_addr), .done(done), .fill_valid(fill_valid), .fill_data(fill_data),
    .err(err), .busy_cycles(busy_cycles), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [127:0] mem [logic [27:0]];

  int           r_done, r_rd, r_wr, r_gap;
  logic         r_fv, r_both;
  logic [27:0]  r_wa, r_ra;
  logic [127:0] r_wd;

  localparam logic [127:0] D_FILL1 = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] D_WB    = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [127:0] D_FILL2 = 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003;
  localparam logic [127:0] D_FILL3 = 128'h0BAD_F00D_AAAA_5555_AAAA_5555_AAAA_5555;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one command from a falling edge and services memory until done (bounded).
  task automatic run_cmd(input logic wb, input logic fill, input logic [27:0] wa,
                         input logic [127:0] wd, input logic [27:0] fa,
                         input logic [127:0] rdat, input int lw, input int lr,
                         input bit silent);
    int wcnt, rcnt, last_wr, first_rd;
    r_done = 0; r_rd = 0; r_wr = 0; r_fv = 1'b0; r_both = 1'b0;
    r_wa = 28'd0; r_ra = 28'd0; r_wd = 128'd0;
    wcnt = 0; rcnt = 0; last_wr = 0; first_rd = 0;
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    wb_addr = wa; wb_data = wd; fill_addr = fa;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      mem_ready = 1'b0;
      if (mem_read && mem_write) r_both = 1'b1;
      if (mem_write) begin
        r_wr++; wcnt++; last_wr = c; r_wa = mem_addr; r_wd = mem_wdata;
        if (!silent && wcnt == lw) begin
          mem_ready = 1'b1;
          mem[mem_addr] = mem_wdata;
        end
      end
      if (mem_read) begin
        r_rd++; rcnt++; r_ra = mem_addr;
        if (first_rd == 0) first_rd = c;
        if (!silent && rcnt == lr) begin
          mem_ready = 1'b1;
          mem_rdata = rdat;
        end
      end
      if (done) begin
        r_done = c;
        r_fv = fill_valid;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    mem_ready = 1'b0;
    r_gap = (last_wr > 0 && first_rd > 0) ? (first_rd - last_wr - 1) : -1;
    check_eq("done_seen", 128'(r_done != 0), 128'd1);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    int saw_done, dn, rdc;
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    wb_addr = 28'd0; wb_data = 128'd0; fill_addr = 28'd0;
    mem_rdata = 128'd0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", req_ready, 1'b1);
    check_eq("rst_rw_done_fv_err", {mem_read, mem_write, done, fill_valid, err}, 5'b0);
    check_eq("rst_addr", mem_addr, 28'd0);
    check_eq("rst_wdata", mem_wdata, 128'd0);
    check_eq("rst_fill_data", fill_data, 128'd0);
    check_eq("rst_busy", busy_cycles, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Refill only, latency 4
    run_cmd(1'b0, 1'b1, 28'd0, 128'd0, 28'h0000010, D_FILL1, 0, 4, 1'b0);
    check_eq("r1_rd_cycles", r_rd, 4);
    check_eq("r1_wr_cycles", r_wr, 0);
    check_eq("r1_addr", r_ra, 28'h0000010);
    check_eq("r1_done_cycle", r_done, 5);
    check_eq("r1_fill_valid", r_fv, 1'b1);
    check_eq("r1_fill_data", fill_data, D_FILL1);
    check_eq("r1_busy", busy_cycles, 16'd5);

    // Command with neither flag is ignored
    req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || mem_read || mem_write || !req_ready) saw_done++;
      @(posedge clk); @(negedge clk);
    end
    check_eq("nop_no_activity", saw_done, 0);
    check_eq("nop_busy", busy_cycles, 16'd5);

    // Write-back then refill, Lw=3 Lr=2
    run_cmd(1'b1, 1'b1, 28'h0000020, D_WB, 28'h0000030, D_FILL2, 3, 2, 1'b0);
    check_eq("wf_wr_cycles", r_wr, 3);
    check_eq("wf_rd_cycles", r_rd, 2);
    check_eq("wf_gap", r_gap, 1);
    check_eq("wf_never_both", r_both, 1'b0);
    check_eq("wf_wr_addr", r_wa, 28'h0000020);
    check_eq("wf_wr_data", r_wd, D_WB);
    check_eq("wf_rd_addr", r_ra, 28'h0000030);
    check_eq("wf_mem_block", mem[28'h0000020], D_WB);
    check_eq("wf_done_cycle", r_done, 7);
    check_eq("wf_fill_valid", r_fv, 1'b1);
    check_eq("wf_fill_data", fill_data, D_FILL2);

    // Write-back only, Lw=2
    run_cmd(1'b1, 1'b0, 28'h0000040, ~D_WB, 28'h0000077, D_FILL3, 2, 1, 1'b0);
    check_eq("wb_done_cycle", r_done, 3);
    check_eq("wb_fill_valid", r_fv, 1'b0);
    check_eq("wb_no_read", r_rd, 0);
    check_eq("wb_fill_kept", fill_data, D_FILL2);
    check_eq("wb_mem_block", mem[28'h0000040], ~D_WB);

    // Timeout: memory silent, wb+fill
    run_cmd(1'b1, 1'b1, 28'h0000060, D_WB, 28'h0000070, D_FILL3, 0, 0, 1'b1);
    check_eq("to_wr_cycles", r_wr, TO);
    check_eq("to_no_read", r_rd, 0);
    check_eq("to_done_cycle", r_done, TO + 1);
    check_eq("to_fill_valid", r_fv, 1'b0);
    check_eq("to_err", err, 1'b1);

    // Good refill afterwards: err stays set
    run_cmd(1'b0, 1'b1, 28'd0, 128'd0, 28'h0000011, D_FILL3, 0, 3, 1'b0);
    check_eq("post_to_done_cycle", r_done, 4);
    check_eq("post_to_fill_valid", r_fv, 1'b1);
    check_eq("post_to_fill_data", fill_data, D_FILL3);
    check_eq("post_to_err_sticky", err, 1'b1);

    // Asynchronous reset while mem_read is high
    req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1; fill_addr = 28'h0000044;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    check_eq("rmid_read_high", mem_read, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rmid_read_low", mem_read, 1'b0);
    check_eq("rmid_ready", req_ready, 1'b1);
    check_eq("rmid_err", err, 1'b0);
    check_eq("rmid_addr", mem_addr, 28'd0);
    check_eq("rmid_fill_data", fill_data, 128'd0);
    check_eq("rmid_busy", busy_cycles, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 1'b1, 28'd0, 128'd0, 28'h0000012, D_FILL1, 0, 1, 1'b0);
    check_eq("rpost_done_cycle", r_done, 2);
    check_eq("rpost_addr", r_ra, 28'h0000012);
    check_eq("rpost_fill_data", fill_data, D_FILL1);

    // req_valid held high: accepts only in IDLE, one command every 3 cycles at L=1
    dn = 0; rdc = 0;
    req_valid = 1'b1; req_wb = 1'b0; req_fill = 1'b1; fill_addr = 28'h0000050;
    @(posedge clk); @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      mem_ready = 1'b0;
      if (done) dn++;
      if (mem_read) begin
        rdc++;
        mem_ready = 1'b1;
        mem_rdata = D_FILL2;
      end
      if (c == 30) req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    mem_ready = 1'b0;
    check_eq("hold_done_count", dn, 10);
    check_eq("hold_read_count", rdc, 10);
    check_eq("hold_idle_after", {req_ready, mem_read}, 2'b10);

    // busy_cycles saturation
    force dut.busy_cycles = 16'hFFFD;
    #1 release dut.busy_cycles;
    run_cmd(1'b0, 1'b1, 28'd0, 128'd0, 28'h0000013, D_FILL3, 0, 4, 1'b0);
    check_eq("sat_busy", busy_cycles, 16'hFFFF);
    @(posedge clk); @(negedge clk);
    check_eq("sat_busy_idle", busy_cycles, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
